// File: rtl/reg_write_arb_pkg.sv
// rtl/reg_write_arb_pkg.sv - shared types and constants for the register write arbiter
package reg_write_arb_pkg;

  // Arbiter phases: wait for a request, drive the register, acknowledge the winner
  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    WRITE = 2'b01,
    ACK   = 2'b10
  } arb_state_e;

  localparam int DEFAULT_N_REQ = 4;

endpackage

// File: rtl/reg_write_arbiter_rr_pick.sv
// rtl/reg_write_arbiter_rr_pick.sv - combinational round-robin winner search starting at rr_ptr
module rr_pick
  import reg_write_arb_pkg::*;
#(
  parameter int N_REQ = DEFAULT_N_REQ,
  parameter int IDX_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] Req,
  input  logic [IDX_W-1:0] rr_ptr,
  output logic             found,
  output logic [IDX_W-1:0] win_idx
);

  logic [IDX_W-1:0] idx;

  // Scan rr_ptr, rr_ptr+1, ... wrapping by explicit compare so non-power-of-two N_REQ works
  always_comb begin
    found   = 1'b0;
    win_idx = '0;
    idx     = rr_ptr;
    for (int i = 0; i < N_REQ; i++) begin
      if (!found && Req[idx]) begin
        found   = 1'b1;
        win_idx = idx;
      end
      idx = (idx == IDX_W'(N_REQ - 1)) ? '0 : idx + IDX_W'(1);
    end
  end

endmodule

// File: rtl/reg_write_arbiter.sv
// rtl/reg_write_arbiter.sv - round-robin arbiter for one shared register; REG_WRITE_ARB_OWNER_EN adds owner tracking
module reg_write_arbiter
  import reg_write_arb_pkg::*;
#(
  parameter int  N_REQ  = DEFAULT_N_REQ,
  parameter int  DATA_W = 32,
  localparam int IDX_W  = $clog2(N_REQ)
) (
  input  logic                    Clock,
  input  logic                    Reset,
  input  logic [N_REQ-1:0]        Req,
  input  logic [N_REQ*DATA_W-1:0] Wr_data,
  output logic [N_REQ-1:0]        Grant,
  output logic [N_REQ-1:0]        Ack,
  output logic                    Reg_en,
  output logic [DATA_W-1:0]       Reg_data,
  output logic                    Busy
`ifdef REG_WRITE_ARB_OWNER_EN
  ,
  output logic [IDX_W-1:0]        Last_owner,
  output logic                    Owner_valid
`endif
);

  arb_state_e        state_q, state_d;
  logic [IDX_W-1:0]  rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0]  sel_q, sel_d;
  logic [DATA_W-1:0] data_hold_q, data_hold_d;
  logic [N_REQ-1:0]  grant_q, grant_d;
  logic [N_REQ-1:0]  ack_q, ack_d;
  logic              reg_en_q, reg_en_d;
  logic              found;
  logic [IDX_W-1:0]  win_idx;
  logic [DATA_W-1:0] win_data;
`ifdef REG_WRITE_ARB_OWNER_EN
  logic [IDX_W-1:0]  last_owner_q, last_owner_d;
  logic              owner_valid_q, owner_valid_d;
`endif

  rr_pick #(
    .N_REQ (N_REQ),
    .IDX_W (IDX_W)
  ) u_rr_pick (
    .Req     (Req),
    .rr_ptr  (rr_ptr_q),
    .found   (found),
    .win_idx (win_idx)
  );

  // Select the winner's data slice with a constant-index mux
  always_comb begin
    win_data = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (win_idx == IDX_W'(i)) win_data = Wr_data[i*DATA_W +: DATA_W];
    end
  end

  // Next-state and registered-output decisions; grant/ack/enable are pulses unless set here
  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    sel_d       = sel_q;
    data_hold_d = data_hold_q;
    grant_d     = '0;
    ack_d       = '0;
    reg_en_d    = 1'b0;
`ifdef REG_WRITE_ARB_OWNER_EN
    last_owner_d  = last_owner_q;
    owner_valid_d = owner_valid_q;
`endif
    case (state_q)
      IDLE: begin
        if (found) begin
          sel_d       = win_idx;
          data_hold_d = win_data;
          grant_d     = N_REQ'(1) << win_idx;
          reg_en_d    = 1'b1;
          state_d     = WRITE;
        end
      end
      WRITE: begin
        ack_d    = N_REQ'(1) << sel_q;
        rr_ptr_d = (sel_q == IDX_W'(N_REQ - 1)) ? '0 : sel_q + IDX_W'(1);
        state_d  = ACK;
`ifdef REG_WRITE_ARB_OWNER_EN
        last_owner_d  = sel_q;
        owner_valid_d = 1'b1;
`endif
      end
      ACK: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers; reset abandons any write in flight
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state_q     <= IDLE;
      rr_ptr_q    <= '0;
      sel_q       <= '0;
      data_hold_q <= '0;
      grant_q     <= '0;
      ack_q       <= '0;
      reg_en_q    <= 1'b0;
`ifdef REG_WRITE_ARB_OWNER_EN
      last_owner_q  <= '0;
      owner_valid_q <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      sel_q       <= sel_d;
      data_hold_q <= data_hold_d;
      grant_q     <= grant_d;
      ack_q       <= ack_d;
      reg_en_q    <= reg_en_d;
`ifdef REG_WRITE_ARB_OWNER_EN
      last_owner_q  <= last_owner_d;
      owner_valid_q <= owner_valid_d;
`endif
    end
  end

  assign Grant    = grant_q;
  assign Ack      = ack_q;
  assign Reg_en   = reg_en_q;
  assign Reg_data = data_hold_q;
  assign Busy     = (state_q != IDLE);
`ifdef REG_WRITE_ARB_OWNER_EN
  assign Last_owner  = last_owner_q;
  assign Owner_valid = owner_valid_q;
`endif

endmodule

// File: tb/tb_reg_write_arbiter.sv
// tb/tb_reg_write_arbiter.sv - self-checking bench for reg_write_arbiter with a phase-level reference model
module tb_reg_write_arbiter;

  localparam int N = 4;
  localparam int W = 32;

  logic           Clock = 1'b0;
  logic           Reset;
  logic [N-1:0]   Req;
  logic [N*W-1:0] Wr_data;
  logic [N-1:0]   Grant;
  logic [N-1:0]   Ack;
  logic           Reg_en;
  logic [W-1:0]   Reg_data;
  logic           Busy;
`ifdef REG_WRITE_ARB_OWNER_EN
  logic [1:0]     Last_owner;
  logic           Owner_valid;
`endif

  reg_write_arbiter #(.N_REQ(N), .DATA_W(W)) dut (
    .Clock    (Clock),
    .Reset    (Reset),
    .Req      (Req),
    .Wr_data  (Wr_data),
    .Grant    (Grant),
    .Ack      (Ack),
    .Reg_en   (Reg_en),
    .Reg_data (Reg_data),
    .Busy     (Busy)
`ifdef REG_WRITE_ARB_OWNER_EN
    ,
    .Last_owner  (Last_owner),
    .Owner_valid (Owner_valid)
`endif
  );

  always #5 Clock = ~Clock;

  int n_total = 0;
  int n_pass  = 0;
  int cyc     = 0;

  always @(posedge Clock) cyc <= cyc + 1;

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
  endfunction

  // The shared register sitting behind the arbiter
  logic [W-1:0] shreg;
  always @(posedge Clock or negedge Reset) begin
    if (!Reset) shreg <= '0;
    else if (Reg_en) shreg <= Reg_data;
  end

  // Reference model: phase 0 = waiting, 1 = register being written, 2 = acknowledging
  function automatic int pick(logic [N-1:0] r, int ptr);
    for (int k = 0; k < N; k++) begin
      if (r[(ptr + k) % N]) return (ptr + k) % N;
    end
    return 0;
  endfunction

  function automatic logic [W-1:0] pick_data(logic [N-1:0] r, int ptr, logic [N*W-1:0] d);
    int j;
    j = pick(r, ptr);
    return d[j*W +: W];
  endfunction

  int           m_phase, m_ptr, m_w, m_last;
  logic [W-1:0] m_data;
  bit           m_valid;

  always @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      m_phase <= 0; m_ptr <= 0; m_w <= 0; m_data <= '0; m_last <= 0; m_valid <= 1'b0;
    end else begin
      case (m_phase)
        0: if (Req != '0) begin
          m_w     <= pick(Req, m_ptr);
          m_data  <= pick_data(Req, m_ptr, Wr_data);
          m_phase <= 1;
        end
        1: begin
          m_ptr   <= (m_w + 1) % N;
          m_last  <= m_w;
          m_valid <= 1'b1;
          m_phase <= 2;
        end
        default: m_phase <= 0;
      endcase
    end
  end

  function automatic int oh2idx(logic [N-1:0] v);
    for (int i = 0; i < N; i++) if (v[i]) return i;
    return -1;
  endfunction

  int           wr_idx[$];
  logic [W-1:0] wr_dat[$];
  int           wr_cyc[$];
  int           ack_idx[$];
  int           ack_cyc[$];

  // Per-cycle comparison against the model, plus a log of writes and acks
  always @(negedge Clock) begin
    check("busy",   32'(Busy),   32'(m_phase != 0));
    check("reg_en", 32'(Reg_en), 32'(m_phase == 1));
    check("grant",  32'(Grant),  (m_phase == 1) ? (32'd1 << m_w) : 32'd0);
    check("ack",    32'(Ack),    (m_phase == 2) ? (32'd1 << m_w) : 32'd0);
    if (m_phase == 1) check("reg_data", Reg_data, m_data);
`ifdef REG_WRITE_ARB_OWNER_EN
    check("last_owner",  32'(Last_owner),  32'(m_last));
    check("owner_valid", 32'(Owner_valid), 32'(m_valid));
`endif
    if (Reg_en) begin
      wr_idx.push_back(oh2idx(Grant));
      wr_dat.push_back(Reg_data);
      wr_cyc.push_back(cyc);
    end
    if (Ack != '0) begin
      ack_idx.push_back(oh2idx(Ack));
      ack_cyc.push_back(cyc);
    end
  end

  task automatic tick(int n);
    repeat (n) @(posedge Clock);
    #1;
  endtask

  task automatic clear_logs();
    wr_idx.delete(); wr_dat.delete(); wr_cyc.delete();
    ack_idx.delete(); ack_cyc.delete();
  endtask

  int exp_order[5] = '{0, 1, 2, 3, 0};
  logic [W-1:0] exp_burst[5] = '{32'd8, 32'd16, 32'd10, 32'd6, 32'd8};

  initial begin
    Reset   = 1'b0;
    Req     = 4'b1111;
    Wr_data = {32'd6, 32'd10, 32'd16, 32'd8};
    tick(2);
    check("rst_grant", 32'(Grant), 32'd0);
    check("rst_ack", 32'(Ack), 32'd0);
    check("rst_reg_en", 32'(Reg_en), 32'd0);
    check("rst_reg_data", Reg_data, 32'd0);
    check("rst_busy", 32'(Busy), 32'd0);
    Reset = 1'b1;

    // All four requesting continuously
    tick(14);
    Req = '0;
    tick(3);
    check("burst_count", wr_idx.size(), 5);
    check("burst_acks", ack_idx.size(), 5);
    if (wr_idx.size() == 5) begin
      for (int k = 0; k < 5; k++) begin
        check("burst_order", wr_idx[k], exp_order[k]);
        check("burst_data", wr_dat[k], exp_burst[k]);
        if (k > 0) check("burst_spacing", wr_cyc[k] - wr_cyc[k-1], 3);
      end
    end
    clear_logs();

    // Single request from requester 2
    Wr_data[2*W +: W] = 32'hDEAD_BEEF;
    Req = 4'b0100;
    tick(2);
    Req = '0;
    tick(3);
    check("single_count", wr_idx.size(), 1);
    check("single_ack_count", ack_idx.size(), 1);
    if (wr_idx.size() == 1 && ack_idx.size() == 1) begin
      check("single_idx", wr_idx[0], 2);
      check("single_data", wr_dat[0], 32'hDEAD_BEEF);
      check("single_ack_idx", ack_idx[0], 2);
      check("single_ack_lat", ack_cyc[0] - wr_cyc[0], 1);
    end
    check("single_shreg", shreg, 32'hDEAD_BEEF);
`ifdef REG_WRITE_ARB_OWNER_EN
    check("single_owner", 32'(Last_owner), 32'd2);
`endif
    clear_logs();

    // Wrap: pointer now at 3
    Req = 4'b1001;
    tick(5);
    Req = '0;
    tick(3);
    check("wrap_count", wr_idx.size(), 2);
    if (wr_idx.size() == 2) begin
      check("wrap_first", wr_idx[0], 3);
      check("wrap_second", wr_idx[1], 0);
    end
    clear_logs();

    // Data changes after being sampled
    Wr_data[1*W +: W] = 32'd5;
    Req = 4'b0010;
    tick(1);
    Wr_data[1*W +: W] = 32'd9;
    tick(1);
    Req = '0;
    tick(3);
    check("hold_count", wr_idx.size(), 1);
    if (wr_idx.size() == 1) check("hold_data", wr_dat[0], 32'd5);
    check("hold_shreg", shreg, 32'd5);
    clear_logs();

    // Reset in the middle of a write
    Wr_data[0 +: W] = 32'd77;
    Req = 4'b0001;
    tick(1);
    check("pre_rst_en", 32'(Reg_en), 32'd1);
    #2;
    Reset = 1'b0;
    #1;
    check("mid_rst_en", 32'(Reg_en), 32'd0);
    check("mid_rst_grant", 32'(Grant), 32'd0);
    check("mid_rst_ack", 32'(Ack), 32'd0);
    check("mid_rst_busy", 32'(Busy), 32'd0);
    check("mid_rst_shreg", shreg, 32'd0);
`ifdef REG_WRITE_ARB_OWNER_EN
    check("mid_rst_owner_valid", 32'(Owner_valid), 32'd0);
`endif
    Req = '0;
    tick(2);
    check("mid_rst_no_ack", ack_idx.size(), 0);
    Reset = 1'b1;
    clear_logs();
    Req = 4'b1010;
    tick(2);
    Req = '0;
    tick(3);
    check("post_rst_count", wr_idx.size(), 1);
    if (wr_idx.size() == 1) check("post_rst_ptr0", wr_idx[0], 1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
